// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - 2-digit multiplexed common-anode 7-segment scanner for packed BCD
// Scan is SHOW_LO, BLANK_LO, SHOW_HI, BLANK_HI; the shadow value only changes at the scan boundary.
module bcd_display_scanner #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4,
  parameter int LZ_BLANK     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       bcd_valid,
  output logic       bcd_ready,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       digit_err
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    SHOW_LO  = 2'd0,
    BLANK_LO = 2'd1,
    SHOW_HI  = 2'd2,
    BLANK_HI = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shadow_q, shadow_d;
  logic [7:0]       pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             err_q, err_d;
  logic             slot_last;
  logic             xfer;
  logic             load_edge;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = 7'h3F;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BLANK_HI;
      cnt_q       <= '0;
      shadow_q    <= 8'h00;
      pend_q      <= 8'h00;
      pend_full_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      err_q       <= err_d;
    end
  end

  assign bcd_ready = !pend_full_q;
  assign xfer      = bcd_valid && bcd_ready;
  assign slot_last = (state_q == SHOW_LO || state_q == SHOW_HI) ? (cnt_q == SHOW_LAST)
                                                               : (cnt_q == BLANK_LAST);
  assign load_edge = (state_q == BLANK_HI) && slot_last;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    if (slot_last) begin
      cnt_d = '0;
      case (state_q)
        SHOW_LO:  state_d = BLANK_LO;
        BLANK_LO: state_d = SHOW_HI;
        SHOW_HI:  state_d = BLANK_HI;
        default:  state_d = SHOW_LO;
      endcase
    end
  end

  // A transfer on the boundary with nothing pending bypasses the pending register.
  always_comb begin
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    err_d       = err_q;
    if (load_edge && pend_full_q) begin
      shadow_d    = pend_q;
      pend_full_d = 1'b0;
      err_d       = (pend_q[7:4] > 4'd9) || (pend_q[3:0] > 4'd9);
    end else if (load_edge && xfer) begin
      shadow_d = bcd_in;
      err_d    = (bcd_in[7:4] > 4'd9) || (bcd_in[3:0] > 4'd9);
    end else if (xfer) begin
      pend_d      = bcd_in;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    an_n  = 2'b11;
    seg_n = 7'h7F;
    case (state_q)
      SHOW_LO: begin
        an_n  = 2'b10;
        seg_n = enc(shadow_q[3:0]);
      end
      SHOW_HI: begin
        if (!((LZ_BLANK != 0) && (shadow_q[7:4] == 4'd0))) begin
          an_n  = 2'b01;
          seg_n = enc(shadow_q[7:4]);
        end
      end
      default: begin
        an_n  = 2'b11;
        seg_n = 7'h7F;
      end
    endcase
  end

  assign digit_err = err_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb/tb_bcd_display_scanner.sv - directed self-checking bench for bcd_display_scanner
// Cycle index k counts clock edges since reset; with a 12-cycle scan, SHOW_LO starts at k=2+12n.
module tb_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] bcd_in;
  logic       bcd_valid;
  logic       bcd_ready, bcd_ready0;
  logic [6:0] seg_n, seg_n0;
  logic [1:0] an_n, an_n0;
  logic       digit_err, digit_err0;

  int checks = 0;
  int errors = 0;
  int k = 0;

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready), .seg_n(seg_n), .an_n(an_n), .digit_err(digit_err)
  );

  bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .bcd_valid(bcd_valid),
    .bcd_ready(bcd_ready0), .seg_n(seg_n0), .an_n(an_n0), .digit_err(digit_err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    k = k + 1;
  endtask

  task automatic adv(input int target);
    while (k < target) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [1:0] an, input logic [6:0] seg);
    chk({tag, "_an"}, {6'd0, an_n}, {6'd0, an});
    chk({tag, "_seg"}, {1'b0, seg_n}, {1'b0, seg});
  endtask

  initial begin
    rst_n     = 1'b0;
    bcd_in    = 8'h00;
    bcd_valid = 1'b0;
    tick();
    k = 0;
    chk_disp("rst", 2'b11, 7'h7F);
    chk("rst_ready", {7'd0, bcd_ready}, 8'h01);
    chk("rst_err", {7'd0, digit_err}, 8'h00);
    rst_n = 1'b1;

    // 1: idle scan after reset
    tick();
    chk_disp("t1_blank_hi", 2'b11, 7'h7F);
    tick();
    chk_disp("t1_show_lo", 2'b10, 7'h40);
    adv(6);
    chk_disp("t1_blank_lo", 2'b11, 7'h7F);
    adv(8);
    chk_disp("t1_tens_lz", 2'b11, 7'h7F);
    chk("t1_ready", {7'd0, bcd_ready}, 8'h01);

    // 2: transfer 27 mid SHOW_HI
    adv(9);
    bcd_in = 8'h27; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    chk("t2_ready_low", {7'd0, bcd_ready}, 8'h00);
    adv(13);
    chk_disp("t2_not_torn", 2'b11, 7'h7F);
    tick();
    chk_disp("t2_units", 2'b10, 7'h78);
    chk("t2_ready_back", {7'd0, bcd_ready}, 8'h01);
    adv(20);
    chk_disp("t2_tens", 2'b01, 7'h24);

    // 3: leading-zero suppression on/off
    bcd_in = 8'h05; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    adv(26);
    chk_disp("t3_units", 2'b10, 7'h12);
    adv(32);
    chk_disp("t3_lz1", 2'b11, 7'h7F);
    chk("t3_lz0_an", {6'd0, an_n0}, 8'h01);
    chk("t3_lz0_seg", {1'b0, seg_n0}, 8'h40);

    // 4: invalid nibble then recovery
    bcd_in = 8'h3C; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    chk("t4_err_before_load", {7'd0, digit_err}, 8'h00);
    adv(38);
    chk("t4_err_set", {7'd0, digit_err}, 8'h01);
    chk_disp("t4_units_dash", 2'b10, 7'h3F);
    adv(44);
    chk_disp("t4_tens", 2'b01, 7'h30);
    bcd_in = 8'h12; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    adv(49);
    chk("t4_err_held", {7'd0, digit_err}, 8'h01);
    tick();
    chk("t4_err_clr", {7'd0, digit_err}, 8'h00);
    chk_disp("t4_units2", 2'b10, 7'h24);

    // 5: upstream holds 99 while pending is full
    bcd_in = 8'h31; bcd_valid = 1'b1;
    tick();
    chk("t5_ready_low", {7'd0, bcd_ready}, 8'h00);
    bcd_in = 8'h99;
    adv(62);
    chk_disp("t5_units", 2'b10, 7'h79);
    chk("t5_ready_back", {7'd0, bcd_ready}, 8'h01);
    tick();
    bcd_valid = 1'b0;
    chk("t5_ready_low2", {7'd0, bcd_ready}, 8'h00);
    adv(68);
    chk_disp("t5_tens31", 2'b01, 7'h30);
    adv(74);
    chk_disp("t5_units99", 2'b10, 7'h10);
    adv(80);
    chk_disp("t5_tens99", 2'b01, 7'h10);

    // transfer on the boundary edge with nothing pending goes straight to shadow
    adv(85);
    bcd_in = 8'h46; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    chk_disp("bypass_units", 2'b10, 7'h02);
    chk("bypass_ready", {7'd0, bcd_ready}, 8'h01);

    // 6: reset during SHOW_HI with pending full
    adv(92);
    chk_disp("t6_tens", 2'b01, 7'h19);
    bcd_in = 8'h58; bcd_valid = 1'b1;
    tick();
    bcd_valid = 1'b0;
    chk("t6_pending", {7'd0, bcd_ready}, 8'h00);
    rst_n = 1'b0;
    tick();
    k = 0;
    rst_n = 1'b1;
    chk_disp("t6_rst", 2'b11, 7'h7F);
    chk("t6_rst_ready", {7'd0, bcd_ready}, 8'h01);
    chk("t6_rst_err", {7'd0, digit_err}, 8'h00);
    adv(2);
    chk_disp("t6_units", 2'b10, 7'h40);
    adv(8);
    chk_disp("t6_tens", 2'b11, 7'h7F);
    adv(14);
    chk_disp("t6_no_pending", 2'b10, 7'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
